// File: rtl/fetch_pkg.sv
// Shared types, ROM window defaults and address-legality helper for the fetch sequencer.
package fetch_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'hBFC00000;
    localparam int unsigned DEF_MEM_BYTES = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // 33-bit compare so a window ending at 2^32 cannot alias to low addresses.
    function automatic logic addr_legal(input logic [31:0] a, input logic [31:0] base,
                                        input int unsigned bytes);
        logic [32:0] w_lo;
        logic [32:0] w_hi;
        logic [32:0] w_a;
        w_lo = {1'b0, base};
        w_hi = {1'b0, base} + 33'(bytes) - 33'd4;
        w_a  = {1'b0, a};
        return (a[1:0] == 2'b00) && (w_a >= w_lo) && (w_a <= w_hi);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Skid FIFO of fetch entries; flush wins over push/pop, head is presented combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 din,
    output fetch_entry_t                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !rst) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills the skid FIFO, handles redirects and fetch faults.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int unsigned MEM_BYTES  = DEF_MEM_BYTES,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_nxt;
    logic          r_fault;
    logic          w_fault_nxt;
    logic [31:0]   r_fault_addr;
    logic [31:0]   w_fault_addr_nxt;
    logic [31:0]   r_fetch_count;

    logic          w_redir;
    logic          w_pc_legal;
    logic          w_tgt_legal;
    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_entry;

    assign w_redir     = redirect && (r_state != FAULT);
    assign w_pc_legal  = addr_legal(r_pc, BASE_ADDR, MEM_BYTES);
    assign w_tgt_legal = addr_legal(redirect_pc, BASE_ADDR, MEM_BYTES);
    assign out_valid   = (w_count != '0);
    assign w_pop       = out_valid && out_ready && !w_redir;
    assign w_push      = (r_state == RUN) && !w_redir && w_pc_legal && (!w_full || w_pop);
    assign w_entry     = '{pc: r_pc, instr: imem_rd};

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_redir),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_entry),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= BASE_ADDR;
            r_fault       <= 1'b0;
            r_fault_addr  <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_fault      <= w_fault_nxt;
            r_fault_addr <= w_fault_addr_nxt;
            if (w_pop) r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // Redirect overrides everything; otherwise the state decides PC advance and fault capture.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_fault_nxt      = r_fault;
        w_fault_addr_nxt = r_fault_addr;
        if (w_redir) begin
            if (w_tgt_legal) begin
                w_pc_nxt = redirect_pc;
            end else begin
                w_state_nxt      = FAULT;
                w_fault_nxt      = 1'b1;
                w_fault_addr_nxt = redirect_pc;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) w_state_nxt = RUN;
                end
                RUN: begin
                    if (!w_pc_legal) begin
                        w_state_nxt      = FAULT;
                        w_fault_nxt      = 1'b1;
                        w_fault_addr_nxt = r_pc;
                    end else begin
                        if (w_push) w_pc_nxt = r_pc + 32'd4;
                        if (!en)    w_state_nxt = IDLE;
                    end
                end
                FAULT: ;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign out_instr   = w_head.instr;
    assign out_pc      = w_head.pc;
    assign fault       = r_fault;
    assign fault_addr  = r_fault_addr;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a queue-based behavioural model of the fetch rules.
module tb_fetch_ctrl;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst, en, redirect, out_ready;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rd;
    logic        out_valid, fault;
    logic [31:0] out_instr, out_pc, fault_addr, fetch_count;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state: mode 0 = idle, 1 = fetching, 2 = faulted.
    int          m_mode;
    logic [31:0] m_pc, m_faddr, m_cnt;
    logic        m_fault;
    logic [63:0] m_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[31:16]};
    endfunction

    assign imem_rd = rom_word(imem_addr);

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .fault       (fault),
        .fault_addr  (fault_addr),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        longint unsigned v;
        v = 64'(a);
        return (a[1:0] == 2'b00) && (v >= 64'(BASE)) && (v <= 64'(BASE) + 64'd4092);
    endfunction

    task automatic model_step();
        bit redir, pop, push;
        if (rst) begin
            m_mode = 0; m_pc = BASE; m_fault = 1'b0; m_faddr = '0; m_cnt = '0;
            m_q.delete();
            return;
        end
        redir = redirect && (m_mode != 2);
        pop   = (m_q.size() > 0) && out_ready && !redir;
        push  = (m_mode == 1) && !redir && legal(m_pc) && ((m_q.size() < 2) || pop);
        if (pop) begin
            void'(m_q.pop_front());
            m_cnt = m_cnt + 32'd1;
        end
        if (push) m_q.push_back({m_pc, rom_word(m_pc)});
        if (redir) begin
            m_q.delete();
            if (legal(redirect_pc)) m_pc = redirect_pc;
            else begin m_mode = 2; m_fault = 1'b1; m_faddr = redirect_pc; end
        end else if (m_mode == 0) begin
            if (en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!legal(m_pc)) begin
                m_mode = 2; m_fault = 1'b1; m_faddr = m_pc;
            end else begin
                if (push) m_pc = m_pc + 32'd4;
                if (!en) m_mode = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
        if (m_q.size() > 0) begin
            chk("out_pc", out_pc, m_q[0][63:32]);
            chk("out_instr", out_instr, m_q[0][31:0]);
        end
        chk("fault", {31'b0, fault}, {31'b0, m_fault});
        chk("fault_addr", fault_addr, m_faddr);
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic e, input logic rd,
                         input logic [31:0] rpc, input logic ry);
        rst = r; en = e; redirect = rd; redirect_pc = rpc; out_ready = ry;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] rand_target();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k < 5)      return BASE + 32'($urandom_range(0, 1023)) * 32'd4;
        else if (k < 7) return BASE + 32'd4092 - 32'($urandom_range(0, 3)) * 32'd4;
        else if (k == 7) return BASE + 32'($urandom_range(0, 4095)) | 32'd1;
        else if (k == 8) return 32'hFFFFFFFC;
        else             return BASE + 32'd4096;
    endfunction

    initial begin
        // Reset and free-running stream
        drive(1, 1, 0, '0, 1);
        run(2);
        chk("rst_pc", imem_addr, BASE);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        drive(0, 1, 0, '0, 1);
        run(20);

        // Backpressure: FIFO fills, PC holds
        drive(0, 1, 0, '0, 0);
        run(5);
        drive(0, 1, 0, '0, 1);
        run(5);

        // Redirect while a pop is pending
        drive(0, 1, 1, BASE + 32'h100, 1);
        step();
        drive(0, 1, 0, '0, 1);
        run(3);

        // Redirect to last ROM word: one fetch then overrun fault
        drive(0, 1, 1, BASE + 32'hFFC, 1);
        step();
        drive(0, 1, 0, '0, 1);
        run(6);
        chk("overrun_addr", fault_addr, 32'hBFC01000);
        chk("overrun_fault", {31'b0, fault}, 32'd1);

        drive(1, 1, 0, '0, 1);
        step();
        drive(0, 1, 0, '0, 1);
        run(6);

        // Misaligned redirect: sticky fault, FIFO stays empty
        drive(0, 1, 1, BASE + 32'h102, 1);
        step();
        drive(0, 1, 0, '0, 1);
        run(5);
        chk("misalign_addr", fault_addr, 32'hBFC00102);

        drive(1, 1, 0, '0, 1);
        step();
        drive(0, 1, 0, '0, 1);
        run(6);

        // Enable low mid-stream, then reset with a full FIFO
        drive(0, 0, 0, '0, 1);
        run(3);
        drive(0, 1, 0, '0, 0);
        run(5);
        drive(1, 1, 0, '0, 0);
        step();
        chk("rst_full_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_full_cnt", fetch_count, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 19) == 0),
                  rand_target(),
                  ($urandom_range(0, 9) < 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the byte-addressed instruction ROM mapped at 0xBFC00000–0xBFC00FFF.
- Owns the PC and drives the ROM address. The ROM returns a 32-bit little-endian word combinationally in the same cycle.
- Captures each {pc, instr} pair into a small skid FIFO that feeds decode over a valid/ready handshake.
- Handles redirects from branch resolution and traps fetches that are misaligned or outside the ROM window.

Parameters:
- BASE_ADDR, 32'hBFC00000, first byte of the instruction ROM; PC reset value.
- MEM_BYTES, 4096, ROM window size in bytes; legal word addresses are BASE_ADDR .. BASE_ADDR+MEM_BYTES-4.
- FIFO_DEPTH, 2, skid FIFO entries; must be a power of 2, ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  fetch enable; while low, no new fetches issue
- imem_addr  out  32  byte address to the instruction ROM (= current PC)
- imem_rd  in  32  instruction word returned by the ROM for imem_addr, same cycle
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc
- redirect_pc  in  32  redirect target byte address
- out_valid  out  1  FIFO head holds a valid instruction
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  32  instruction at FIFO head
- out_pc  out  32  PC of instruction at FIFO head
- fault  out  1  sticky fetch fault
- fault_addr  out  32  address that caused the fault
- fetch_count  out  32  number of instructions accepted by decode

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: pc = BASE_ADDR, FIFO empty, out_valid = 0, fault = 0, fault_addr = 0, fetch_count = 0, state = IDLE. imem_addr always equals pc.
- Push condition: push = state==RUN && !redirect && (count < FIFO_DEPTH || pop). The entry written is {pc, imem_rd}, and pc advances by 4 on every push.
- Pop condition: pop = out_valid && out_ready && !redirect. fetch_count increments by 1 on each pop and wraps modulo 2^32.
- Latency: an instruction is visible on out_* the cycle after its push, so redirect-to-first-out_valid is 2 cycles.
- Throughput: when out_ready is held high, one instruction per cycle with no bubbles.
- IDLE state: no push. Go to RUN when en = 1.
- RUN state: push when possible. Go to IDLE when en = 0; the FIFO is retained and still drains.
- FAULT state: no push and no PC change. The FIFO still drains. Leave only by rst.
- Legality rule: an address a is legal iff a[1:0] == 0 and BASE_ADDR ≤ a ≤ BASE_ADDR+MEM_BYTES-4. Use 33-bit compare so wrap at 2^32 cannot alias.
- Redirect: highest priority; accepted in any state except FAULT.
  - The FIFO is flushed, so out_valid = 0 next cycle. A simultaneous pop is discarded and fetch_count does not increment.
  - If redirect_pc is legal, pc <= redirect_pc and the state is unchanged.
  - If redirect_pc is illegal, state <= FAULT, fault <= 1, fault_addr <= redirect_pc, and pc holds.
- Sequential overrun: in RUN with pc illegal (e.g. after fetching BASE_ADDR+MEM_BYTES-4), no push occurs. Instead state <= FAULT and fault_addr <= pc, one cycle after the last legal push.
- FIFO full with no pop: pc and the ROM address hold; no push occurs.
- Reset mid-operation: all state returns to reset values next edge and in-flight entries are discarded.

Decomposition:
- Package fetch_pkg holds:
  - the BASE_ADDR and MEM_BYTES localparam defaults
  - the state enum typedef fetch_state_t {IDLE, RUN, FAULT}
  - the fetch entry struct fetch_entry_t {pc[31:0], instr[31:0]}
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t. It has a flush input (priority over push/pop), simultaneous push+pop when full, a count output, and head-ahead output.

Test Plan:
- rst, en=1, out_ready=1, ROM preloaded with words 0x00000013 at every address -> out_valid from cycle 2; out_pc = 0xBFC00000, 0xBFC00004, … one per cycle; fetch_count counts up by 1 per cycle.
- out_ready=0 for 5 cycles mid-stream -> count saturates at 2, imem_addr holds, no lost/duplicate PCs when out_ready returns to 1.
- redirect=1, redirect_pc=0xBFC00100 while out_valid=1 and out_ready=1 -> that pop is dropped (fetch_count unchanged); next cycle out_valid=0; following cycle out_pc=0xBFC00100.
- redirect_pc=0xBFC00102 (misaligned) -> fault=1, fault_addr=0xBFC00102, no further out_valid; an empty FIFO stays empty until rst.
- redirect_pc=0xBFC00FFC, out_ready=1 -> one instruction at 0xBFC00FFC delivered, then fault=1, fault_addr=0xBFC01000.
- en=0 for 3 cycles mid-stream, then rst asserted with FIFO full -> no fetch while en=0; after rst, out_valid=0, pc=0xBFC00000, fault=0, fetch_count=0.
